// File: rtl/cim_pkg.sv
// Shared types and constants for the CIM row driver.
package cim_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_STROBE = 3'd2,
        COMPUTE   = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_CHAIN = 2'b01;
    localparam logic [1:0] OP_LOCAL = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

endpackage

// File: rtl/cim_wl_decoder.sv
// One-hot word-line decoder; an out-of-range row index yields all zeros.
module cim_wl_decoder #(
    parameter int ROWS = 4,
    parameter int RW   = $clog2(ROWS)
) (
    input  logic [RW-1:0]   row,
    input  logic            en,
    output logic [ROWS-1:0] wl
);

    // Raise the single bit matching the row index when enabled.
    always_comb begin
        wl = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (en && (32'(row) == i)) begin
                wl[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cim_row_driver.sv
// Command sequencer for a compute-in-memory array: row writes and
// settle-timed XNOR computes with a valid/ready result port.
module cim_row_driver
    import cim_pkg::*;
#(
    parameter int COLS   = 8,
    parameter int ROWS   = 4,
    parameter int SETTLE = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic [1:0]               CMD_OP,
    input  logic [$clog2(ROWS)-1:0]  CMD_ROW,
    input  logic [COLS-1:0]          CMD_DATA,
    output logic [ROWS-1:0]          WL,
    output logic [COLS-1:0]          BL,
    output logic                     WE,
    output logic                     CE,
    output logic                     SI0,
    input  logic [COLS-1:0]          RD_BITS,
    output logic                     RES_VALID,
    input  logic                     RES_READY,
    output logic [COLS-1:0]          RES_DATA,
    output logic                     ERR
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          state;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   cnt;
    logic [ROWS-1:0] wl_dec;

    cim_wl_decoder #(
        .ROWS (ROWS),
        .RW   (RW)
    ) u_wl_decoder (
        .row (row_q),
        .en  (state == WR_SETUP),
        .wl  (wl_dec)
    );

    // Ready is gated by reset so it drops the instant reset asserts and
    // rises as soon as reset is released.
    assign CMD_READY = (state == IDLE) && !RST;
    assign SI0       = 1'b0;

    // Sequencer FSM with registered array-side and result outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            row_q     <= '0;
            cnt       <= '0;
            WL        <= '0;
            BL        <= '0;
            WE        <= 1'b0;
            CE        <= 1'b0;
            ERR       <= 1'b0;
            RES_VALID <= 1'b0;
            RES_DATA  <= '0;
        end else begin
            ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        row_q <= CMD_ROW;
                        cnt   <= '0;
                        case (CMD_OP)
                            OP_WRITE: begin
                                state <= WR_SETUP;
                                BL    <= CMD_DATA;
                                ERR   <= !(32'(CMD_ROW) < 32'(ROWS));
                            end
                            OP_CHAIN, OP_LOCAL: begin
                                state <= COMPUTE;
                                BL    <= CMD_DATA;
                                WE    <= 1'b1;
                                CE    <= (CMD_OP == OP_CHAIN);
                            end
                            default: ERR <= 1'b1;
                        endcase
                    end
                end
                WR_SETUP: begin
                    // An out-of-range row decodes to zero: skip the strobe.
                    if (wl_dec != '0) begin
                        WL    <= wl_dec;
                        state <= WR_STROBE;
                    end else begin
                        BL    <= '0;
                        state <= IDLE;
                    end
                end
                WR_STROBE: begin
                    WL    <= '0;
                    BL    <= '0;
                    state <= IDLE;
                end
                COMPUTE: begin
                    if (cnt == CW'(SETTLE - 1)) begin
                        RES_DATA  <= RD_BITS;
                        RES_VALID <= 1'b1;
                        BL        <= '0;
                        WE        <= 1'b0;
                        CE        <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (RES_READY) begin
                        RES_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_row_driver.sv
// Self-checking bench for cim_row_driver: directed scenarios plus random
// commands checked cycle by cycle against a transaction-level model.
module tb_cim_row_driver;
    import cim_pkg::*;

    localparam int COLS   = 8;
    localparam int ROWS   = 5;
    localparam int SETTLE = 2;
    localparam int RW     = $clog2(ROWS);

    logic            CLK = 1'b0;
    logic            RST;
    logic            CMD_VALID;
    logic            CMD_READY;
    logic [1:0]      CMD_OP;
    logic [RW-1:0]   CMD_ROW;
    logic [COLS-1:0] CMD_DATA;
    logic [ROWS-1:0] WL;
    logic [COLS-1:0] BL;
    logic            WE;
    logic            CE;
    logic            SI0;
    logic [COLS-1:0] RD_BITS;
    logic            RES_VALID;
    logic            RES_READY;
    logic [COLS-1:0] RES_DATA;
    logic            ERR;

    int vectors     = 0;
    int miscompares = 0;

    logic            rd_force = 1'b0;
    logic [COLS-1:0] rd_val   = '0;

    cim_row_driver #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .SETTLE (SETTLE)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_ROW   (CMD_ROW),
        .CMD_DATA  (CMD_DATA),
        .WL        (WL),
        .BL        (BL),
        .WE        (WE),
        .CE        (CE),
        .SI0       (SI0),
        .RD_BITS   (RD_BITS),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES_DATA  (RES_DATA),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    // Array response: new value shortly after each rising edge.
    initial begin
        RD_BITS = '0;
        forever begin
            @(posedge CLK);
            #2;
            RD_BITS = rd_force ? rd_val : COLS'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] snap(input logic [ROWS-1:0] wl, input logic [COLS-1:0] bl,
                                         input logic we, input logic ce, input logic err,
                                         input logic rv, input logic rdy);
        return 32'({wl, bl, we, ce, err, rv, rdy});
    endfunction

    function automatic logic [31:0] obs();
        return snap(WL, BL, WE, CE, ERR, RES_VALID, CMD_READY);
    endfunction

    function automatic logic [31:0] idle_snap();
        return snap('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    // Wait for ready, present the command, step to the middle of cycle T+1
    // and scramble the command inputs to prove they were latched.
    task automatic accept(input logic [1:0] op, input logic [2:0] row, input logic [COLS-1:0] data,
                          output bit ok);
        int waited = 0;
        @(negedge CLK);
        while (!CMD_READY && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        check("ready_wait", 32'(CMD_READY), 32'd1);
        ok = CMD_READY;
        if (!ok) return;
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_ROW   = RW'(row);
        CMD_DATA  = data;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_OP    = 2'($urandom);
        CMD_ROW   = RW'($urandom);
        CMD_DATA  = COLS'($urandom);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [2:0] row, input logic [COLS-1:0] data,
                          input int hold, input bit fixed_rd, input logic [COLS-1:0] fixed_val,
                          input bit pester);
        bit              ok;
        logic [COLS-1:0] exp_res;
        logic [ROWS-1:0] onehot;
        rd_force = fixed_rd;
        rd_val   = fixed_val;
        exp_res  = '0;
        accept(op, row, data, ok);
        if (!ok) return;
        if (op == OP_WRITE && 32'(row) < ROWS) begin
            onehot = '0;
            onehot[row] = 1'b1;
            check("wr_setup", obs(), snap('0, data, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            @(negedge CLK);
            check("wr_strobe", obs(), snap(onehot, data, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            @(negedge CLK);
            check("wr_idle", obs(), idle_snap());
        end else if (op == OP_WRITE) begin
            check("wr_badrow", obs(), snap('0, data, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
            @(negedge CLK);
            check("wr_badrow_idle", obs(), idle_snap());
        end else if (op == OP_RSVD) begin
            check("rsvd_err", obs(), snap('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
            @(negedge CLK);
            check("rsvd_idle", obs(), idle_snap());
        end else begin
            for (int k = 1; k <= SETTLE; k++) begin
                check("compute", obs(), snap('0, data, 1'b1, op == OP_CHAIN, 1'b0, 1'b0, 1'b0));
                if (k == SETTLE) exp_res = RD_BITS;
                @(negedge CLK);
            end
            for (int h = 0; h <= hold; h++) begin
                if (pester) begin
                    CMD_VALID = 1'b1;
                    CMD_OP    = OP_RSVD;
                end
                check("done", obs(), snap('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
                check("res_data", 32'(RES_DATA), 32'(exp_res));
                RES_READY = (h == hold);
                @(negedge CLK);
            end
            RES_READY = 1'b0;
            check("cmp_idle", obs(), idle_snap());
            if (pester) begin
                @(negedge CLK);
                check("first_idle_accept", obs(), snap('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
                CMD_VALID = 1'b0;
                @(negedge CLK);
                check("after_pester", obs(), idle_snap());
            end
        end
        rd_force = 1'b0;
    endtask

    initial begin
        bit ok;
        RST       = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP    = '0;
        CMD_ROW   = '0;
        CMD_DATA  = '0;
        RES_READY = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_state", obs(), snap('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        check("reset_res", 32'(RES_DATA), 32'd0);
        check("si0", 32'(SI0), 32'd0);
        RST = 1'b0;
        #1;
        check("ready_after_reset", 32'(CMD_READY), 32'd1);

        // Directed scenarios.
        do_cmd(OP_WRITE, 3'd2, 8'hA5, 0, 1'b0, '0, 1'b0);
        do_cmd(OP_CHAIN, 3'd0, 8'h3C, 0, 1'b1, 8'h81, 1'b0);
        do_cmd(OP_LOCAL, 3'd0, 8'h5A, 5, 1'b1, 8'h6E, 1'b0);
        do_cmd(OP_WRITE, 3'd5, 8'hFF, 0, 1'b0, '0, 1'b0);
        do_cmd(OP_RSVD,  3'd0, 8'h00, 0, 1'b0, '0, 1'b0);
        do_cmd(OP_CHAIN, 3'd0, 8'hC3, 2, 1'b0, '0, 1'b1);
        do_cmd(OP_WRITE, 3'd4, 8'h01, 0, 1'b0, '0, 1'b0);
        do_cmd(OP_WRITE, 3'd0, 8'h80, 0, 1'b0, '0, 1'b0);

        // Reset during the word-line strobe.
        accept(OP_WRITE, 3'd3, 8'h99, ok);
        if (ok) begin
            @(negedge CLK);
            check("strobe_before_rst", 32'(WL), 32'h8);
            RST = 1'b1;
            #1;
            check("rst_mid_strobe", obs(), snap('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            check("rst_mid_res", 32'(RES_DATA), 32'd0);
            @(negedge CLK);
            RST = 1'b0;
            #1;
            check("ready_after_rst", 32'(CMD_READY), 32'd1);
        end

        // Randomized commands.
        for (int n = 0; n < 60; n++) begin
            do_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), COLS'($urandom),
                   int'($urandom_range(0, 4)), 1'b0, '0, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
